touch_adc_spi_responder: RTL

TOUCH_ADC_SPI_RESPONDER -- requirements
Module: touch_adc_spi_responder

---
 rtl/touch_adc_spi_responder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/touch_adc_spi_responder.sv
// Touch-screen ADC SPI responder: emulates a resistive-touch ADC slave.
// Accepts an 8-bit control byte from the master, then answers with a busy
// period and a 12-bit (or 8-bit) X/Y coordinate, MSB first.
//
// state  | meaning
// IDLE   | no frame in progress, waiting for a start bit
// CMD    | shifting in control byte bits on DCLK rising edges
// BUSY   | conversion emulation; BUSY high for one DCLK period
// DATA   | shifting out coordinate bits on DCLK falling edges
// TAIL   | conversion done, DOUT low, a new start bit may follow
module touch_adc_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] X_ADDR      = 3'b001,
  parameter logic [2:0] Y_ADDR      = 3'b101
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iADC_DCLK,
  input  logic        iADC_CS,
  input  logic        iADC_DIN,
  input  logic        iTOUCH,
  input  logic [11:0] iX_COORD,
  input  logic [11:0] iY_COORD,
  output logic        oADC_DOUT,
  output logic        oADC_BUSY,
  output logic        oADC_PENIRQ_n,
  output logic [7:0]  oCMD,
  output logic        oCMD_VALID,
  output logic        oFRAME_ERR
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_BUSY, S_DATA, S_TAIL} state_t;

  logic [SYNC_STAGES-1:0] dclk_sync_q, dclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  // live_q marks when the synchronizers hold real pin samples, not reset values
  logic [SYNC_STAGES-1:0] live_q, live_d;
  logic        dclk_prev_q, dclk_prev_d;
  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  cmd_sr_q, cmd_sr_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [11:0] data_sr_q, data_sr_d;
  logic [3:0]  len_q, len_d;
  logic        dout_q, dout_d;
  logic        busy_q, busy_d;
  logic        pen_en_q, pen_en_d;
  logic        penirq_n_q, penirq_n_d;
  // armed_q blocks start bits after reset until CS has been seen high
  logic        armed_q, armed_d;

  logic        dclk_s, cs_s, din_s, live_s;
  logic        dclk_rise, dclk_fall;
  logic [7:0]  cmd_byte;
  logic [11:0] coord_sel;

  assign dclk_s    = dclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign live_s    = live_q[SYNC_STAGES-1];
  assign dclk_rise = dclk_s & ~dclk_prev_q;
  assign dclk_fall = ~dclk_s & dclk_prev_q;
  assign cmd_byte  = {cmd_sr_q, din_s};

  // Synchronizer shift chains and pen interrupt
  always_comb begin
    dclk_sync_d    = dclk_sync_q << 1;
    dclk_sync_d[0] = iADC_DCLK;
    cs_sync_d      = cs_sync_q << 1;
    cs_sync_d[0]   = iADC_CS;
    din_sync_d     = din_sync_q << 1;
    din_sync_d[0]  = iADC_DIN;
    live_d         = live_q << 1;
    live_d[0]      = 1'b1;
    dclk_prev_d    = dclk_s;
    penirq_n_d     = ~(iTOUCH & pen_en_q);
  end

  // Channel decode on the completing control byte
  always_comb begin
    coord_sel = 12'h000;
    if (cmd_byte[6:4] == X_ADDR)      coord_sel = iX_COORD;
    else if (cmd_byte[6:4] == Y_ADDR) coord_sel = iY_COORD;
  end

  // Frame FSM next-state and datapath; CS high overrides any DCLK edge
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_sr_d    = cmd_sr_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    data_sr_d   = data_sr_q;
    len_d       = len_q;
    dout_d      = dout_q;
    busy_d      = busy_q;
    pen_en_d    = pen_en_q;
    armed_d     = armed_q | (live_s & cs_s);
    if (cs_s) begin
      state_d   = S_IDLE;
      dout_d    = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
      if (state_q == S_CMD || state_q == S_BUSY || state_q == S_DATA)
        frame_err_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_TAIL: begin
          dout_d = 1'b0;
          if (dclk_rise && din_s && armed_q) begin
            state_d   = S_CMD;
            cmd_sr_d  = 7'h01;
            bit_cnt_d = 4'd1;
          end
        end
        S_CMD: begin
          if (dclk_rise) begin
            cmd_sr_d  = cmd_byte[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              cmd_d       = cmd_byte;
              cmd_valid_d = 1'b1;
              pen_en_d    = ~cmd_byte[0];
              len_d       = cmd_byte[3] ? 4'd8 : 4'd12;
              data_sr_d   = coord_sel;
              bit_cnt_d   = 4'd0;
              state_d     = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          dout_d = 1'b0;
          if (dclk_fall) begin
            if (!busy_q) begin
              busy_d = 1'b1;
            end else begin
              busy_d    = 1'b0;
              dout_d    = data_sr_q[11];
              data_sr_d = data_sr_q << 1;
              bit_cnt_d = 4'd1;
              state_d   = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (dclk_fall) begin
            if (bit_cnt_q == len_q) begin
              dout_d  = 1'b0;
              state_d = S_TAIL;
            end else begin
              dout_d    = data_sr_q[11];
              data_sr_d = data_sr_q << 1;
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      dclk_sync_q <= '0;
      cs_sync_q   <= '1;
      din_sync_q  <= '0;
      live_q      <= '0;
      dclk_prev_q <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      cmd_sr_q    <= 7'h00;
      cmd_q       <= 8'h00;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      data_sr_q   <= 12'h000;
      len_q       <= 4'd12;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      pen_en_q    <= 1'b1;
      penirq_n_q  <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      dclk_sync_q <= dclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      din_sync_q  <= din_sync_d;
      live_q      <= live_d;
      dclk_prev_q <= dclk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      data_sr_q   <= data_sr_d;
      len_q       <= len_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      pen_en_q    <= pen_en_d;
      penirq_n_q  <= penirq_n_d;
      armed_q     <= armed_d;
    end
  end

  assign oADC_DOUT     = dout_q;
  assign oADC_BUSY     = busy_q;
  assign oADC_PENIRQ_n = penirq_n_q;
  assign oCMD          = cmd_q;
  assign oCMD_VALID    = cmd_valid_q;
  assign oFRAME_ERR    = frame_err_q;

endmodule
